// File: rtl/dmux4way_dispatcher_pkg.sv
// Shared constants and helpers for the 4-way dispatcher.
// Holds the mode encodings, the destination indices and the round-robin search helper.
package dmux4way_dispatcher_pkg;

    // Dispatch mode encodings
    localparam logic MODE_RR     = 1'b0;
    localparam logic MODE_DIRECT = 1'b1;

    // Destination indices
    localparam logic [1:0] DEST_A = 2'd0;
    localparam logic [1:0] DEST_B = 2'd1;
    localparam logic [1:0] DEST_C = 2'd2;
    localparam logic [1:0] DEST_D = 2'd3;

    localparam int unsigned NUM_DEST = 4;

    // Result of a round-robin search: whether any destination is enabled, and which one
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // First enabled destination, scanning ptr, ptr+1, ... modulo 4.
    // The loop runs from the farthest offset down so the nearest hit is written last and wins.
    function automatic rr_pick_t rr_search(input logic [3:0] en, input logic [1:0] ptr);
        rr_pick_t   pick;
        logic [1:0] cand;
        pick = '0;
        for (int k = NUM_DEST - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (en[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dmux4way_dispatcher_dmux4way.sv
// 1-to-4 demultiplexer gate.
// Routes a single-bit input onto one of four outputs selected by sel; the other outputs stay low.
module dmux4way_dispatcher_dmux4way (
    input  logic       din,
    input  logic [1:0] sel,
    output logic [3:0] dout
);

    // Steer din onto the selected output only
    always_comb begin
        dout      = 4'b0000;
        dout[sel] = din;
    end

endmodule

// File: rtl/dmux4way_dispatcher.sv
// Four-way dispatcher: a single valid/ready input stream feeding four sinks.
// A single holding register carries one word. Its destination comes either from a round-robin
// scan over the enabled outputs or from the per-word in_dest field. A completed transfer
// increments that output's counter.
module dmux4way_dispatcher
    import dmux4way_dispatcher_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [3:0]         dest_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_dest,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               drop,
    output logic [4*CNT_W-1:0] xfer_cnt
);

    // Holding register and bookkeeping state
    logic             full_q, full_d;
    logic [1:0]       hold_dest_q, hold_dest_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q [NUM_DEST];
    logic [CNT_W-1:0] cnt_d [NUM_DEST];

    // Handshake and selection terms
    rr_pick_t   rr_pick;
    logic       dest_ok;
    logic       out_fire;
    logic       in_fire;
    logic       drop_now;
    logic       load;
    logic [1:0] sel_dest;

    // Round-robin candidate for the word currently offered
    always_comb begin
        rr_pick = rr_search(dest_en, rr_ptr_q);
    end

    // Handshake, destination choice and drop detection
    always_comb begin
        out_fire = full_q & out_ready[hold_dest_q];
        // Direct mode always accepts, because a word for a disabled output is dropped, not stalled
        dest_ok  = (mode == MODE_DIRECT) ? 1'b1 : (|dest_en);
        in_ready = (~full_q | out_fire) & dest_ok;
        in_fire  = in_valid & in_ready;
        sel_dest = (mode == MODE_DIRECT) ? in_dest : rr_pick.idx;
        drop_now = in_fire & (mode == MODE_DIRECT) & ~dest_en[in_dest];
        load     = in_fire & ~drop_now;
    end

    // Next-state for the holding register, rr pointer and drop pulse
    always_comb begin
        full_d      = full_q;
        hold_dest_d = hold_dest_q;
        hold_data_d = hold_data_q;
        rr_ptr_d    = rr_ptr_q;
        drop_d      = drop_now;

        if (load) begin
            // A reload on the same cycle as out_fire keeps full set, so no bubble appears
            full_d      = 1'b1;
            hold_dest_d = sel_dest;
            hold_data_d = in_data;
            if (mode == MODE_RR) begin
                rr_ptr_d = sel_dest + 2'd1;
            end
        end else if (out_fire) begin
            full_d = 1'b0;
        end
    end

    // Next-state for the per-destination transfer counters (wrap naturally)
    always_comb begin
        for (int i = 0; i < NUM_DEST; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (out_fire) begin
            cnt_d[hold_dest_q] = cnt_q[hold_dest_q] + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 1'b0;
            hold_dest_q <= DEST_A;
            hold_data_q <= '0;
            rr_ptr_q    <= DEST_A;
            drop_q      <= 1'b0;
            for (int i = 0; i < NUM_DEST; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            full_q      <= full_d;
            hold_dest_q <= hold_dest_d;
            hold_data_q <= hold_data_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_q      <= drop_d;
            for (int i = 0; i < NUM_DEST; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // One-hot valid follows full directly, so a reset drops it without waiting for a clock
    dmux4way_dispatcher_dmux4way u_dmux (
        .din  (full_q),
        .sel  (hold_dest_q),
        .dout (out_valid)
    );

    assign out_data = hold_data_q;
    assign drop     = drop_q;

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_cnt
        assign xfer_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_dmux4way_dispatcher.sv
// Self-checking bench for dmux4way_dispatcher.
// A per-cycle monitor compares the DUT against a queue of expected held words and a
// counter/drop model. Directed checks cover the boundary cases.
module tb_dmux4way_dispatcher;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode;
    logic [3:0]       dest_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_dest;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic             drop;
    logic [31:0]      xfer_cnt;

    always #5 clk = ~clk;

    dmux4way_dispatcher #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .dest_en   (dest_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop      (drop),
        .xfer_cnt  (xfer_cnt)
    );

    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned m_cnt[4];
    logic [1:0]  m_rr;
    logic        m_drop_next;
    bit          mon_en;
    int          n_cmp;
    int          n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_rr        = 2'd0;
        m_drop_next = 1'b0;
    endtask

    // Per-cycle monitor: compare outputs against the model, then advance the model
    always @(negedge clk) begin
        logic [3:0]  ev;
        logic [31:0] pc;
        logic        ofire;
        logic        rdy;
        logic        found;
        logic [1:0]  d;
        logic [1:0]  c;
        exp_t        e;
        if (mon_en) begin
            ev = 4'b0000;
            if (sb_q.size() > 0) ev[sb_q[0].dest] = 1'b1;
            check_eq("out_valid", {28'd0, out_valid}, {28'd0, ev});
            if (sb_q.size() > 0) check_eq("out_data", {24'd0, out_data}, {24'd0, sb_q[0].data});
            check_eq("drop", {31'd0, drop}, {31'd0, m_drop_next});
            for (int i = 0; i < 4; i++) pc[i*8 +: 8] = m_cnt[i][7:0];
            check_eq("xfer_cnt", xfer_cnt, pc);

            ofire = (sb_q.size() > 0) && out_ready[sb_q[0].dest];
            rdy   = ((sb_q.size() == 0) || ofire) && (mode ? 1'b1 : (|dest_en));
            check_eq("in_ready", {31'd0, in_ready}, {31'd0, rdy});

            m_drop_next = 1'b0;
            if (ofire) begin
                m_cnt[sb_q[0].dest] = (m_cnt[sb_q[0].dest] + 1) % 256;
                void'(sb_q.pop_front());
            end
            if (in_valid && rdy) begin
                if (mode) begin
                    if (dest_en[in_dest]) begin
                        e.dest = in_dest;
                        e.data = in_data;
                        sb_q.push_back(e);
                    end else begin
                        m_drop_next = 1'b1;
                    end
                end else begin
                    found = 1'b0;
                    d     = 2'd0;
                    for (int k = 0; k < 4; k++) begin
                        c = m_rr + 2'(k);
                        if (!found && dest_en[c]) begin
                            found = 1'b1;
                            d     = c;
                        end
                    end
                    e.dest = d;
                    e.data = in_data;
                    sb_q.push_back(e);
                    m_rr = d + 2'd1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted; the wait is bounded
    task automatic send(input logic [7:0] d, input logic [1:0] dst);
        int   n;
        logic ok;
        n        = 0;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dst;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        dest_en   = 4'b0000;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = 2'd0;
        out_ready = 4'b0000;
        model_clear();

        // Reset state
        #12;
        check_eq("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_drop", {31'd0, drop}, 32'd0);
        check_eq("rst_xfer_cnt", xfer_cnt, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Round robin over all outputs, back to back
        mode      = 1'b0;
        dest_en   = 4'b1111;
        out_ready = 4'b1111;
        send(8'h11, 2'd0);
        check_eq("rr_first_valid", {28'd0, out_valid}, 32'b0001);
        send(8'h22, 2'd0);
        send(8'h33, 2'd0);
        send(8'h44, 2'd0);
        send(8'h55, 2'd0);
        idle(2);
        check_eq("rr_counts", xfer_cnt, 32'h01_01_01_02);

        // Sparse enable mask: dests 1,3,1,3
        dest_en = 4'b1010;
        send(8'h61, 2'd0);
        send(8'h62, 2'd0);
        send(8'h63, 2'd0);
        send(8'h64, 2'd0);
        idle(2);
        check_eq("sparse_counts", xfer_cnt, 32'h03_01_03_02);

        // Held word for dest 2 survives stall and enable removal
        dest_en   = 4'b0100;
        out_ready = 4'b1011;
        send(8'hC3, 2'd0);
        idle(5);
        check_eq("stall_valid", {28'd0, out_valid}, 32'b0100);
        check_eq("stall_data", {24'd0, out_data}, 32'hC3);
        dest_en  = 4'b0000;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        check_eq("noen_in_ready", {31'd0, in_ready}, 32'd0);
        idle(2);
        check_eq("noen_data_stable", {24'd0, out_data}, 32'hC3);
        out_ready = 4'b1111;
        idle(3);
        check_eq("noen_in_ready_after", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        check_eq("stall_delivered", {24'd0, xfer_cnt[23:16]}, 32'd2);

        // Direct mode with a drop to a disabled destination
        mode    = 1'b1;
        dest_en = 4'b0111;
        send(8'hA0, 2'd3);
        check_eq("drop_pulse", {31'd0, drop}, 32'd1);
        check_eq("drop_no_valid", {28'd0, out_valid}, 32'd0);
        send(8'hB0, 2'd0);
        check_eq("direct_valid", {28'd0, out_valid}, 32'b0001);
        check_eq("direct_data", {24'd0, out_data}, 32'hB0);
        idle(2);
        check_eq("direct_cnt0", {24'd0, xfer_cnt[7:0]}, 32'd3);

        // Asynchronous reset while a word is held (round robin picks dest 3)
        mode      = 1'b0;
        dest_en   = 4'b1111;
        out_ready = 4'b0000;
        send(8'h5A, 2'd0);
        check_eq("pre_rst_valid", {28'd0, out_valid}, 32'b1000);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_eq("async_rst_valid", {28'd0, out_valid}, 32'd0);
        check_eq("async_rst_cnt", xfer_cnt, 32'd0);
        model_clear();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        out_ready = 4'b1111;
        send(8'h61, 2'd0);
        check_eq("rr_restart", {28'd0, out_valid}, 32'b0001);
        idle(2);

        // Counter wrap on dest 1
        mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 2'd1);
        end
        idle(3);
        check_eq("wrap_cnt1", {24'd0, xfer_cnt[15:8]}, 32'd0);
        check_eq("wrap_others", xfer_cnt, 32'h00_00_00_01);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
